// File: rtl/jogo_batalha_naval_core_if.sv
// Board-side bundle of the battleship core: player controls in, matrix/LED/status out.
// The master side is the board (switches, debouncer); the slave side is the game core.
interface jogo_batalha_naval_core_if #(
  parameter int LINHAS  = 7,
  parameter int COLUNAS = 5,
  parameter int VIDAS   = 3
);
  localparam int WL = (LINHAS > 1) ? $clog2(LINHAS) : 1;
  localparam int WC = (COLUNAS > 1) ? $clog2(COLUNAS) : 1;
  localparam int WV = $clog2(VIDAS + 1);
  localparam int WA = $clog2(LINHAS * COLUNAS + 1);

  logic [1:0]               modo;
  logic [WL-1:0]            coord_linha;
  logic [WC-1:0]            coord_coluna;
  logic                     confirmar;
  logic [LINHAS*COLUNAS-1:0] mapa_in;

  logic [LINHAS-1:0]        linhas;
  logic [COLUNAS-1:0]       colunas;
  logic                     LED_R;
  logic                     LED_G;
  logic                     LED_B;
  logic [WV-1:0]            vida;
  logic [WA-1:0]            acertos;
  logic [2:0]               estado;

  modport master (
    output modo, coord_linha, coord_coluna, confirmar, mapa_in,
    input  linhas, colunas, LED_R, LED_G, LED_B, vida, acertos, estado
  );

  modport slave (
    input  modo, coord_linha, coord_coluna, confirmar, mapa_in,
    output linhas, colunas, LED_R, LED_G, LED_B, vida, acertos, estado
  );
endinterface

// File: rtl/jogo_batalha_naval_core.sv
// Battleship game core: map latch, shot bookkeeping, lives, win/lose and LED-matrix scan.
// Optional macro CURSOR_BLINK_EN adds a blinking attack cursor and a map reveal at game end.
module jogo_batalha_naval_core #(
  parameter int LINHAS    = 7,
  parameter int COLUNAS   = 5,
  parameter int VIDAS     = 3,
  parameter int SCAN_DIV  = 64,
  parameter int FLASH_CYC = 4096
) (
  input  logic                       clock,
  input  logic                       reset_n,
  jogo_batalha_naval_core_if.slave   bus
);
  localparam int N  = LINHAS * COLUNAS;
  localparam int WV = $clog2(VIDAS + 1);
  localparam int WA = $clog2(N + 1);
  localparam int WI = $clog2(N);
  localparam int WS = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int WK = $clog2(COLUNAS);
  localparam int WF = $clog2(FLASH_CYC + 1);
`ifdef CURSOR_BLINK_EN
  localparam int BLINK_DIV = 32 * SCAN_DIV * COLUNAS;
  localparam int WB        = $clog2(BLINK_DIV);
`endif

  typedef enum logic [2:0] {
    DESLIGADO  = 3'd0,
    PREPARACAO = 3'd1,
    ATAQUE     = 3'd2,
    VITORIA    = 3'd3,
    DERROTA    = 3'd4
  } estado_t;

  typedef enum logic [1:0] {
    LED_NONE,
    LED_VERM,
    LED_VERDE,
    LED_AZUL
  } led_t;

  function automatic logic [WA-1:0] popcount(input logic [N-1:0] v);
    logic [WA-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + WA'(v[i]);
    return s;
  endfunction

  // Game state
  estado_t          r_estado;
  logic [N-1:0]     r_mapa;
  logic [N-1:0]     r_tiro;
  logic             r_mapa_ok;
  logic             r_mapa_travado;
  logic [WA-1:0]    r_alvo;
  logic [WA-1:0]    r_acertos;
  logic [WV-1:0]    r_vida;
  logic [WS-1:0]    r_scan_cnt;
  logic [WK-1:0]    r_col;
  logic [WF-1:0]    r_flash_cnt;
  led_t             r_flash_sel;
`ifdef CURSOR_BLINK_EN
  logic [N-1:0]     r_acerto;
  logic [WB-1:0]    r_blink_cnt;
  logic             r_blink;
`endif

  // Output stage
  estado_t          r_out_estado;
  logic [WV-1:0]    r_out_vida;
  logic [WA-1:0]    r_out_acertos;
  logic [LINHAS-1:0]  r_linhas;
  logic [COLUNAS-1:0] r_colunas;
  logic             r_led_r;
  logic             r_led_g;
  logic             r_led_b;

  logic             w_modo_prep;
  logic             w_modo_atq;
  logic             w_fora;
  logic [WI-1:0]    w_idx;
  logic [WA-1:0]    w_pop;
  logic             w_flash_on;
  led_t             w_evento;
  logic [N-1:0]     w_conteudo;
  logic [LINHAS-1:0] w_linhas_col;

  assign w_modo_prep = (bus.modo == 2'b01);
  assign w_modo_atq  = (bus.modo == 2'b10);
  assign w_fora      = (int'(bus.coord_linha) >= LINHAS) || (int'(bus.coord_coluna) >= COLUNAS);
  assign w_idx       = WI'(int'(bus.coord_linha) * COLUNAS + int'(bus.coord_coluna));
  assign w_pop       = popcount(bus.mapa_in);
  assign w_flash_on  = (r_flash_cnt != '0);

  // Classifies the confirm pulse of this cycle; it drives both bookkeeping and LED pulses.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_evento = LED_NONE;
    if (w_modo_prep && r_estado == PREPARACAO && bus.confirmar && w_pop == '0) begin
      w_evento = LED_AZUL;
    end else if (w_modo_atq && r_estado == ATAQUE && bus.confirmar) begin
      if (w_fora || r_tiro[w_idx]) w_evento = LED_AZUL;
      else if (r_mapa[w_idx])      w_evento = LED_VERDE;
      else                         w_evento = LED_VERM;
    end
  end

  always_comb begin
    w_conteudo = '0;
    case (r_estado)
      PREPARACAO:               w_conteudo = r_mapa_travado ? r_mapa : bus.mapa_in;
      ATAQUE, VITORIA, DERROTA: w_conteudo = r_tiro;
      default:                  w_conteudo = '0;
    endcase
`ifdef CURSOR_BLINK_EN
    if (r_estado == ATAQUE && !w_fora) w_conteudo[w_idx] = w_conteudo[w_idx] ^ r_blink;
    if (r_estado == VITORIA || r_estado == DERROTA)
      w_conteudo = w_conteudo | (r_mapa & ~r_acerto & {N{r_blink}});
`endif
  end

  always_comb begin
    w_linhas_col = '0;
    for (int r = 0; r < LINHAS; r++)
      w_linhas_col[r] = w_conteudo[WI'(r * COLUNAS + int'(r_col))];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: map/shot matrices are plain flops (not RAM), so they take the async reset like any register.
      r_estado       <= DESLIGADO;
      r_mapa         <= '0;
      r_tiro         <= '0;
      r_mapa_ok      <= 1'b0;
      r_mapa_travado <= 1'b0;
      r_alvo         <= '0;
      r_acertos      <= '0;
      r_vida         <= WV'(VIDAS);
      r_scan_cnt     <= '0;
      r_col          <= '0;
      r_flash_cnt    <= '0;
      r_flash_sel    <= LED_NONE;
`ifdef CURSOR_BLINK_EN
      r_acerto       <= '0;
      r_blink_cnt    <= '0;
      r_blink        <= 1'b0;
`endif
      r_out_estado   <= DESLIGADO;
      r_out_vida     <= WV'(VIDAS);
      r_out_acertos  <= '0;
      r_linhas       <= '0;
      r_colunas      <= '0;
      r_led_r        <= 1'b0;
      r_led_g        <= 1'b0;
      r_led_b        <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every read above sees pre-edge values.
      if (w_evento != LED_NONE) begin
        r_flash_cnt <= WF'(FLASH_CYC);
        r_flash_sel <= w_evento;
      end else if (w_flash_on) begin
        r_flash_cnt <= r_flash_cnt - WF'(1);
      end

      if (r_estado != DESLIGADO) begin
        if (r_scan_cnt == WS'(SCAN_DIV - 1)) begin
          r_scan_cnt <= '0;
          r_col      <= (r_col == WK'(COLUNAS - 1)) ? '0 : r_col + WK'(1);
        end else begin
          r_scan_cnt <= r_scan_cnt + WS'(1);
        end
`ifdef CURSOR_BLINK_EN
        if (r_blink_cnt == WB'(BLINK_DIV - 1)) begin
          r_blink_cnt <= '0;
          r_blink     <= ~r_blink;
        end else begin
          r_blink_cnt <= r_blink_cnt + WB'(1);
        end
`endif
      end

      case (bus.modo)
        2'b01: begin
          if (r_estado != PREPARACAO) begin
            r_estado       <= PREPARACAO;
            r_tiro         <= '0;
            r_vida         <= WV'(VIDAS);
            r_acertos      <= '0;
            r_mapa_ok      <= 1'b0;
            r_mapa_travado <= 1'b0;
`ifdef CURSOR_BLINK_EN
            r_acerto       <= '0;
`endif
          end else if (bus.confirmar) begin
            r_mapa         <= bus.mapa_in;
            r_alvo         <= w_pop;
            r_mapa_ok      <= (w_pop != '0);
            r_mapa_travado <= 1'b1;
          end
        end
        2'b10: begin
          case (r_estado)
            PREPARACAO: if (r_mapa_ok) r_estado <= ATAQUE;
            ATAQUE: begin
              if (w_evento == LED_VERDE) begin
                r_tiro[w_idx] <= 1'b1;
`ifdef CURSOR_BLINK_EN
                r_acerto[w_idx] <= 1'b1;
`endif
                r_acertos <= r_acertos + WA'(1);
                if (r_acertos + WA'(1) == r_alvo) r_estado <= VITORIA;
              end else if (w_evento == LED_VERM) begin
                r_tiro[w_idx] <= 1'b1;
                r_vida        <= r_vida - WV'(1);
                if (r_vida == WV'(1)) r_estado <= DERROTA;
              end
            end
            default: ;
          endcase
        end
        default: r_estado <= DESLIGADO;
      endcase

      r_out_estado  <= r_estado;
      r_out_vida    <= r_vida;
      r_out_acertos <= r_acertos;

      if (r_estado == DESLIGADO) begin
        r_linhas  <= '0;
        r_colunas <= '0;
      end else begin
        r_linhas  <= w_linhas_col;
        r_colunas <= COLUNAS'(1) << r_col;
      end

      // End states own their steady LED and mask any other colour.
      r_led_r <= (r_estado == DERROTA) ||
                 (w_flash_on && r_flash_sel == LED_VERM && r_estado != VITORIA);
      r_led_g <= (r_estado == VITORIA) ||
                 (w_flash_on && r_flash_sel == LED_VERDE && r_estado != DERROTA);
      r_led_b <= w_flash_on && r_flash_sel == LED_AZUL &&
                 r_estado != VITORIA && r_estado != DERROTA;
    end
  end

  assign bus.estado  = r_out_estado;
  assign bus.vida    = r_out_vida;
  assign bus.acertos = r_out_acertos;
  assign bus.linhas  = r_linhas;
  assign bus.colunas = r_colunas;
  assign bus.LED_R   = r_led_r;
  assign bus.LED_G   = r_led_g;
  assign bus.LED_B   = r_led_b;
endmodule

// File: tb/tb_jogo_batalha_naval_core.sv
// Bench for jogo_batalha_naval_core: directed game scenarios plus randomized games,
// checked against a cell-array model of the battleship rules.
module tb_jogo_batalha_naval_core;
  localparam int L  = 7;
  localparam int C  = 5;
  localparam int V  = 3;
  localparam int SD = 64;
  localparam int FC = 4096;
  localparam int N  = L * C;
  localparam int WL = $clog2(L);
  localparam int WC = $clog2(C);
  localparam int OFF = 0, PREP = 1, ATK = 2, VIT = 3, DER = 4;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  jogo_batalha_naval_core_if #(.LINHAS(L), .COLUNAS(C), .VIDAS(V)) bus ();

  jogo_batalha_naval_core #(
    .LINHAS(L), .COLUNAS(C), .VIDAS(V), .SCAN_DIV(SD), .FLASH_CYC(FC)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Rule-level model of the game
  int       m_st;
  bit       m_ship [L][C];
  bit       m_shot [L][C];
  bit       m_latched;
  bit       m_ok;
  int       m_vida, m_acertos, m_alvo;
  int       m_led;              // last event colour: 0 none, 1 red, 2 green, 3 blue
  logic [1:0]   cur_modo;
  logic [N-1:0] cur_mapa;

  task automatic model_reset();
    m_st = OFF; m_latched = 0; m_ok = 0; m_vida = V; m_acertos = 0; m_alvo = 0; m_led = 0;
    for (int r = 0; r < L; r++)
      for (int c = 0; c < C; c++) begin m_ship[r][c] = 0; m_shot[r][c] = 0; end
  endtask

  task automatic model_edge(input logic [1:0] m, input int l, input int c, input bit conf,
                            input logic [N-1:0] mp);
    if (m == 2'b00 || m == 2'b11) begin
      m_st = OFF;
    end else if (m == 2'b01) begin
      if (m_st != PREP) begin
        m_st = PREP; m_vida = V; m_acertos = 0; m_ok = 0; m_latched = 0;
        for (int r = 0; r < L; r++)
          for (int k = 0; k < C; k++) m_shot[r][k] = 0;
      end else if (conf) begin
        m_alvo = 0;
        for (int r = 0; r < L; r++)
          for (int k = 0; k < C; k++) begin
            m_ship[r][k] = mp[r*C+k];
            if (m_ship[r][k]) m_alvo++;
          end
        m_ok = (m_alvo != 0);
        m_latched = 1;
        if (!m_ok) m_led = 3;
      end
    end else begin
      if (m_st == PREP && m_ok) begin
        m_st = ATK;
      end else if (m_st == ATK && conf) begin
        if (l >= L || c >= C)   m_led = 3;
        else if (m_shot[l][c])  m_led = 3;
        else begin
          m_shot[l][c] = 1;
          if (m_ship[l][c]) begin
            m_acertos++; m_led = 2;
            if (m_acertos == m_alvo) m_st = VIT;
          end else begin
            m_vida--; m_led = 1;
            if (m_vida == 0) m_st = DER;
          end
        end
      end
    end
  endtask

  function automatic logic [L-1:0] exp_col(input int k);
    logic [L-1:0] v;
    v = '0;
    for (int r = 0; r < L; r++) begin
      if (m_st == PREP)     v[r] = m_latched ? m_ship[r][k] : cur_mapa[r*C+k];
      else if (m_st != OFF) v[r] = m_shot[r][k];
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; inputs change on the falling edge.
  task automatic step(input logic [1:0] m, input int l, input int c, input bit conf,
                      input logic [N-1:0] mp);
    bus.modo = m; bus.coord_linha = WL'(l); bus.coord_coluna = WC'(c);
    bus.confirmar = conf; bus.mapa_in = mp;
    cur_modo = m; cur_mapa = mp;
    @(posedge clock);
    model_edge(m, l, c, conf, mp);
    @(negedge clock);
    bus.confirmar = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(cur_modo, 0, 0, 1'b0, cur_mapa);
  endtask

  task automatic act(input logic [1:0] m, input int l, input int c, input bit conf,
                     input logic [N-1:0] mp);
    step(m, l, c, conf, mp);
    idle(2);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_estado"},  bus.estado,  m_st);
    check({tag, "_vida"},    bus.vida,    m_vida);
    check({tag, "_acertos"}, bus.acertos, m_acertos);
  endtask

  task automatic check_leds(input string tag);
    logic [2:0] e;
    if (m_st == VIT)      e = 3'b010;
    else if (m_st == DER) e = 3'b100;
    else case (m_led)
      1: e = 3'b100;
      2: e = 3'b010;
      3: e = 3'b001;
      default: e = 3'b000;
    endcase
    check({tag, "_leds"}, {bus.LED_R, bus.LED_G, bus.LED_B}, e);
  endtask

  // Follows the column scan through a full wrap, checking order, dwell and row data.
  task automatic check_scan(input string tag);
    logic [C-1:0] prev, cur, e;
    int budget, dwell, k;
    prev = bus.colunas;
    budget = 0;
    while (bus.colunas == prev && budget < 4 * SD) begin @(negedge clock); budget++; end
    check({tag, "_scan_sync"}, budget < 4 * SD, 1);
    for (int n = 0; n <= C; n++) begin
      cur = bus.colunas;
      e = {prev[C-2:0], prev[C-1]};
      check({tag, "_colunas"}, cur, e);
      k = 0;
      for (int i = 0; i < C; i++) if (cur[i]) k = i;
      check({tag, "_linhas"}, bus.linhas, exp_col(k));
      dwell = 0;
      while (bus.colunas == cur && dwell < 4 * SD) begin @(negedge clock); dwell++; end
      check({tag, "_dwell"}, dwell, SD);
      prev = cur;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] mapa_a, mp;
    int hi, w, ns, l, c, pick;
    bit seen;
    int ship_l[$];
    int ship_c[$];

    mapa_a = '0;
    mapa_a[0] = 1'b1;
    mapa_a[1*C+2] = 1'b1;

    model_reset();
    reset_n = 1'b0;
    bus.modo = 2'b00; bus.coord_linha = '0; bus.coord_coluna = '0;
    bus.confirmar = 1'b0; bus.mapa_in = '0;
    cur_modo = 2'b00; cur_mapa = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    idle(2);
    check_status("reset");
    check("reset_linhas", bus.linhas, 0);
    check("reset_colunas", bus.colunas, 0);
    check_leds("reset");

    // Preparation: live map display, then latched map display
    act(2'b01, 0, 0, 1'b0, mapa_a);
    check_status("prep_entry");
    check_scan("prep_live");
    act(2'b01, 0, 0, 1'b1, mapa_a);
    mp = N'(64'h5_5555_5555);
    act(2'b01, 0, 0, 1'b0, mp);
    check_scan("prep_latched");
    act(2'b10, 0, 0, 1'b0, mapa_a);
    check_status("atk_entry");

    // Hit, pulse length, then win
    step(2'b10, 0, 0, 1'b1, mapa_a);
    hi = 0; w = 0; seen = 0;
    while (w < FC + 200) begin
      @(negedge clock); w++;
      if (bus.LED_G) begin hi++; seen = 1; end
      else if (seen) break;
    end
    check("flash_len_green", hi, FC);
    check_status("hit1");
    check_scan("atk_after_hit");
    act(2'b10, 1, 2, 1'b1, mapa_a);
    check_status("win");
    check_leds("win");
    idle(100);
    check_leds("win_steady");
    act(2'b10, 1, 2, 1'b1, mapa_a);
    check_status("win_confirm_ignored");

    // Misses, repeat and out-of-range shots, defeat
    act(2'b01, 0, 0, 1'b0, mapa_a);
    act(2'b01, 0, 0, 1'b1, mapa_a);
    act(2'b10, 0, 0, 1'b0, mapa_a);
    act(2'b10, 6, 4, 1'b1, mapa_a); check_status("miss1"); check_leds("miss1");
    act(2'b10, 5, 4, 1'b1, mapa_a); check_status("miss2"); check_leds("miss2");
    act(2'b10, 6, 4, 1'b1, mapa_a); check_status("repeat"); check_leds("repeat");
    check_scan("after_repeat");
    act(2'b10, 7, 0, 1'b1, mapa_a); check_status("out_of_range"); check_leds("out_of_range");
    act(2'b10, 4, 4, 1'b1, mapa_a); check_status("defeat"); check_leds("defeat");
    act(2'b10, 0, 0, 1'b1, mapa_a); check_status("defeat_confirm_ignored"); check_leds("defeat_hold");

    // Empty map is rejected
    act(2'b01, 0, 0, 1'b0, '0);
    act(2'b01, 0, 0, 1'b1, '0);
    check_status("empty_map"); check_leds("empty_map");
    act(2'b10, 0, 0, 1'b0, '0);
    check_status("empty_map_attack");

    // Off blanks the matrix
    act(2'b11, 0, 0, 1'b0, '0);
    check_status("off");
    check("off_linhas", bus.linhas, 0);
    check("off_colunas", bus.colunas, 0);

    // Randomized games
    for (int g = 0; g < 8; g++) begin
      act(2'b01, 0, 0, 1'b0, '0);
      mp = '0;
      ship_l.delete(); ship_c.delete();
      ns = $urandom_range(1, 4);
      for (int i = 0; i < ns; i++) begin
        l = $urandom_range(0, L - 1); c = $urandom_range(0, C - 1);
        mp[l*C+c] = 1'b1;
        ship_l.push_back(l); ship_c.push_back(c);
      end
      act(2'b01, 0, 0, 1'b1, mp);
      act(2'b10, 0, 0, 1'b0, mp);
      check_status("rnd_start");
      for (int s = 0; s < 30 && m_st == ATK; s++) begin
        if ($urandom_range(0, 1) == 1) begin
          pick = $urandom_range(0, ship_l.size() - 1);
          l = ship_l[pick]; c = ship_c[pick];
        end else begin
          l = $urandom_range(0, 7); c = $urandom_range(0, 7);
        end
        act(2'b10, l, c, 1'b1, mp);
        check_status("rnd_shot");
        check_leds("rnd_shot");
      end
      if (m_st != ATK) begin
        act(2'b10, 0, 0, 1'b1, mp);
        check_status("rnd_end_hold");
      end
      check_scan("rnd_scan");
    end

    // Async reset in the middle of an attack
    act(2'b01, 0, 0, 1'b0, mapa_a);
    act(2'b01, 0, 0, 1'b1, mapa_a);
    act(2'b10, 0, 0, 1'b0, mapa_a);
    act(2'b10, 0, 0, 1'b1, mapa_a);
    act(2'b10, 3, 3, 1'b1, mapa_a);
    check_status("pre_async_reset");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_status("async_reset");
    check("async_reset_linhas", bus.linhas, 0);
    check("async_reset_colunas", bus.colunas, 0);
    check("async_reset_leds", {bus.LED_R, bus.LED_G, bus.LED_B}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    act(2'b00, 0, 0, 1'b0, '0);
    check_status("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jogo_batalha_naval_core.md
Name: jogo_batalha_naval_core

Overview:
- Parametrised battleship game core for an LED-matrix board of LINHAS x COLUNAS cells.
- Absorbs the map latch, attack bookkeeping, lives counter, win/lose detection and matrix scanning into one registered block.
- Sits between the board I/O (mode switches, coordinate switches, debounced confirm pulse, map selector output) and the matrix/RGB-LED pins.
- Adds behaviour the previous single-size design lacked: win detection, repeat-shot rejection, out-of-range rejection and explicit end states.

Parameters:
- LINHAS, 7, matrix rows (2..16).
- COLUNAS, 5, matrix columns (2..16).
- VIDAS, 3, misses allowed before defeat (1..15).
- SCAN_DIV, 64, clocks each column stays active (>=1).
- FLASH_CYC, 4096, clocks a hit/miss/repeat LED pulse lasts (>=1).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- modo  in  2  00 or 11 = off, 01 = preparation, 10 = attack.
- coord_linha  in  WL=max(1,$clog2(LINHAS))  attack row.
- coord_coluna  in  WC=max(1,$clog2(COLUNAS))  attack column.
- confirmar  in  1  one-clock pulse, already debounced.
- mapa_in  in  LINHAS*COLUNAS  candidate map; bit index = linha*COLUNAS+coluna; 1 = ship.
- linhas  out  LINHAS  row drive for the active column, active-high.
- colunas  out  COLUNAS  one-hot column select, active-high.
- LED_R, LED_G, LED_B  out  1 each  status LEDs.
- vida  out  WV=$clog2(VIDAS+1)  remaining lives.
- acertos  out  WA=$clog2(LINHAS*COLUNAS+1)  hits so far.
- estado  out  3  0 DESLIGADO, 1 PREPARACAO, 2 ATAQUE, 3 VITORIA, 4 DERROTA.

Behaviour:
- Reset (async, reset_n=0):
  - estado=DESLIGADO; vida=VIDAS; acertos=0.
  - Map, shot and hit registers cleared; mapa_ok=0; alvo=0.
  - linhas=0, colunas=0; all LEDs 0; scan counters 0.
- All outputs are registered. A confirmar at edge N is reflected on the outputs after edge N+1.
- modo=off from any state goes to DESLIGADO. Registers are held and the matrix is blanked (linhas=0, colunas=0).
- modo=01 from DESLIGADO, ATAQUE, VITORIA or DERROTA enters PREPARACAO. On that entry:
  - clear shot and hit matrices; vida=VIDAS; acertos=0; mapa_ok=0.
- In PREPARACAO, confirmar:
  - latches mapa_in into mapa;
  - sets alvo = popcount(mapa_in);
  - sets mapa_ok = (popcount != 0). A map with zero ship cells is rejected: mapa_ok=0 and LED_B pulses.
- modo=10 while in PREPARACAO:
  - mapa_ok=1: go to ATAQUE.
  - mapa_ok=0: stay in PREPARACAO.
- modo=10 from DESLIGADO stays in DESLIGADO.
- In ATAQUE, confirmar with idx = coord_linha*COLUNAS+coord_coluna:
  - coord_linha>=LINHAS or coord_coluna>=COLUNAS: ignored, no state change, LED_B pulse.
  - shot[idx]=1 (repeat shot): ignored, LED_B pulse.
  - Ship cell: shot[idx]=1, hit[idx]=1, acertos+1, LED_G pulse. If acertos+1==alvo, go to VITORIA.
  - Water cell: shot[idx]=1, vida-1, LED_R pulse. If vida==1, go to DERROTA.
- VITORIA holds LED_G=1 steady. DERROTA holds LED_R=1 steady.
  - In both states confirmar is ignored; only a modo change leaves them.
- confirmar in DESLIGADO is ignored.
- LED pulses:
  - each lasts exactly FLASH_CYC clocks;
  - a new event restarts the pulse and clears the other two LEDs;
  - only one LED is lit at a time.
- Matrix content:
  - PREPARACAO shows mapa_in live until latched, then the latched mapa.
  - ATAQUE, VITORIA and DERROTA show the shot matrix.
- Scan:
  - column k is active for SCAN_DIV clocks; colunas[k]=1 and linhas = content bits of column k;
  - k wraps from COLUNAS-1 to 0;
  - scan counters free-run in every non-off state.

Optional Feature:
- Macro CURSOR_BLINK_EN.
- When defined:
  - in ATAQUE, the cell at the current in-range coordinates is XOR-ed with a blink bit;
  - the blink bit toggles every 32*SCAN_DIV*COLUNAS clocks;
  - in VITORIA and DERROTA, unhit ship cells blink to reveal the map.
- When undefined: content is exactly as described above, with no blink logic.

Test Plan:
- Reset, then release with modo=00 -> estado=0, vida=3, acertos=0, linhas=0, colunas=0, all LEDs 0.
- modo=01, mapa_in with ships at (0,0),(1,2), confirmar; modo=10 -> estado=2. colunas cycles 00001→00010→…→10000, each for 64 clocks.
- Shoot (0,0) then (1,2) -> acertos=1 after the first shot with LED_G lit for 4096 clocks; estado=3 (VITORIA) and LED_G steady after the second.
- Same map; miss at (6,4), (5,4), (4,4) -> vida goes 2,1,0; estado=4 (DERROTA) with LED_R steady; a further confirmar changes nothing.
- Repeat (6,4) then shoot (7,0) -> vida unchanged; LED_B pulses each time; shot matrix unchanged.
- mapa_in=0 with confirmar, then modo=10 -> estado stays 1 and LED_B pulses. Assert reset_n mid-ATAQUE -> all registers return to reset values asynchronously.
